// File: rtl/pll_reset_sequencer.sv
// PLL power-up and lock supervisor: sequences the PLL RESETB, qualifies LOCK,
// retries on timeout and releases the core reset once lock has been stable.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       core_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_count,
  output logic [2:0] state_o
);

  localparam int RET_W = $clog2(MAX_RETRIES + 2);
  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [RET_W-1:0] retries, retries_nx;
  logic [7:0]       relock_nx;
  logic             sync1, lock_s;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= locked;
      lock_s <= sync1;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    retries_nx = retries;
    relock_nx  = relock_count;
    if (restart) begin
      state_nx   = PLL_RST;
      cnt_nx     = RST_LOAD;
      retries_nx = '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == '0) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = TIMEOUT_LOAD;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        WAIT_LOCK: begin
          // lock takes precedence over a timeout landing on the same cycle
          if (lock_s) begin
            state_nx = STABLE;
            cnt_nx   = STABLE_LOAD;
          end else if (cnt == '0) begin
            if (retries < RET_MAX) begin
              retries_nx = retries + 1'b1;
              state_nx   = PLL_RST;
              cnt_nx     = RST_LOAD;
            end else begin
              state_nx = FAIL;
            end
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = TIMEOUT_LOAD;
          end else if (cnt == '0) begin
            state_nx   = RUN;
            retries_nx = '0;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nx = PLL_RST;
            cnt_nx   = RST_LOAD;
            if (relock_count != 8'hFF) relock_nx = relock_count + 1'b1;
          end
        end
        FAIL: begin
          state_nx = FAIL;
        end
        default: begin
          state_nx = PLL_RST;
          cnt_nx   = RST_LOAD;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they align with state and never glitch.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PLL_RST;
      cnt          <= RST_LOAD;
      retries      <= '0;
      relock_count <= '0;
      pll_resetb   <= 1'b0;
      core_reset_n <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      retries      <= retries_nx;
      relock_count <= relock_nx;
      pll_resetb   <= (state_nx == WAIT_LOCK) || (state_nx == STABLE) || (state_nx == RUN);
      core_reset_n <= (state_nx == RUN);
      fail         <= (state_nx == FAIL);
    end
  end

  assign ready   = core_reset_n;
  assign state_o = state;

endmodule
